bcd_conv_sched: RTL and testbench
=================================

# bcd_conv_sched

Round-robin scheduler that time-shares a single 2-digit binary-to-BCD converter among up to four clock-value requesters: seconds, minutes, hours and alarm. It sits between the timekeeping counters and the display digit registers. It latches each requester's 7-bit value, converts it, stores the two BCD digits per channel, and pulses a per-channel acknowledge. This replaces one converter instance per displayed field.

## Interface
- `N_CH`, default 4: number of requesters (2..4).
- `W`, default 7: binary operand width.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `en`  in  1  global enable for new grants.
- `req`  in  N_CH  per-channel conversion request; level or pulse.
- `bin_flat`  in  N_CH*W  channel i operand at bits [i*W +: W]; held stable from request until ack.
- `ack`  out  N_CH  one-cycle pulse: channel i result now valid.
- `bcd_flat`  out  N_CH*8  channel i result at [i*8 +: 8], tens in the upper nibble.
- `ovf`  out  N_CH  channel i last operand exceeded 99.
- `busy`  out  1  a conversion is in flight or a request is pending.

## Operation
- `pending[i]` is set on any edge where `req[i]`=1.
  - A repeat request while pending merges, giving one conversion.
  - `req[i]`=1 on the same edge that `pending[i]` is cleared by a grant keeps it set. This produces a new, second conversion.
- The FSM has two states, IDLE and CONV.
- IDLE, when `en`=1 and `pending`≠0:
  - Pick grant g: the first set bit at or after `rr_ptr`, wrapping at N_CH.
  - Register `operand <= bin[g]` and `gnt_idx <= g`.
  - Clear `pending[g]`, set `rr_ptr <= (g+1) mod N_CH`, go to CONV.
- IDLE, otherwise: stay in IDLE.
- CONV, always:
  - Capture the converter output into `bcd[gnt_idx]`.
  - Set `ovf[gnt_idx] <= (operand > 99)`.
  - Pulse `ack[gnt_idx]`, return to IDLE.
- Operand > 99: stored digits are forced to 9,9 (saturate) and ovf is set. Otherwise ovf is cleared.
- `en`=0 blocks new grants only.
  - An in-flight CONV still completes.
  - Pending bits keep accumulating.
- Converter is purely combinational, driven from `operand`. Outputs are two 4-bit digits, each 0..9.
- Reset values:
  - state=IDLE, `rr_ptr`=0, `pending`=0, `operand`=0.
  - `ack`=0, `bcd_flat`=0, `ovf`=0, `busy`=0.
- Reset mid-CONV aborts the conversion: no ack, results cleared.

## Timing
- Request sampled at edge k sets pending.
- Grant happens at edge k+1 if IDLE and `en`=1.
- Capture happens at edge k+2; `ack` is high for the cycle after k+2.
- `bcd`/`ovf` of the channel are valid in the same cycle as `ack` and hold until that channel's next capture.
- Throughput: one conversion every 2 cycles back-to-back. Worst-case wait with N_CH channels is 2·N_CH cycles after pending is set.
- At most one `ack` bit is high in any cycle.
- `busy` is registered: `busy = (next_state==CONV) | (|next_pending)`.

## Structure
- Shared package `clock_defs_pkg` holds:
  - state encoding (IDLE=0, CONV=1);
  - `BCD_W`=4;
  - `BCD_MAX_VAL`=99;
  - the saturation digit value 9.
- Sub-module `rr_arb`, parameterised N_CH, takes `pending` and `rr_ptr` and produces one-hot grant, grant index and a valid flag. It is purely combinational; the pointer update stays in the parent.
- Instantiate the existing converter `bin2dec2` once; saturation is applied outside it.

## Test plan
- Single request: ch1 `bin`=59, `req[1]` pulse at edge 0 → `ack[1]` in the cycle after edge 2, `bcd[1]`=8'h59, `ovf[1]`=0, `busy` low afterwards.
- Simultaneous requests: all four at one edge with values 0, 7, 23, 99 → acks in order ch0..ch3, one every 2 cycles. Results 8'h00, 8'h07, 8'h23, 8'h99; `rr_ptr` ends at 0.
- Overflow: ch2 `bin`=127 → `bcd[2]`=8'h99, `ovf[2]`=1. Then `bin`=42 → 8'h42, `ovf[2]`=0.
- Fairness:
  - ch0 `req` held high continuously and ch2 pulsed once → ch2 acked within 4 cycles of its pending bit, and ch0 never acked twice consecutively while ch2 is pending.
  - Two `req[3]` pulses before its grant → exactly one `ack[3]`.
- Enable and reset:
  - `en`=0 with ch1 pending → no ack for 10 cycles, `busy`=1. Raising `en` → ack 2 cycles later.
  - `rst_n` low during CONV → no ack, all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/clock_defs_pkg.sv
// clock_defs_pkg: shared encodings and constants for the clock display datapath
package clock_defs_pkg;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;
    localparam int BCD_W = 4;
    localparam int BCD_MAX_VAL = 99;
    localparam logic [BCD_W-1:0] SAT_DIGIT = 4'd9;
endpackage

// File: rtl/bin2dec2.sv
// bin2dec2: combinational binary to two-digit BCD converter
// ports: bin (W-bit operand) -> tens, ones (4-bit digits, valid for bin <= 99)
module bin2dec2
    import clock_defs_pkg::*;
#(
    parameter int W = 7
) (
    input  logic [W-1:0]     bin,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);
    assign tens = BCD_W'(bin / W'(10));
    assign ones = BCD_W'(bin % W'(10));
endmodule

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin picker, first pending bit at or after ptr
// ports: pending, ptr -> gnt (one-hot), idx (grant index), valid (any pending)
module rr_arb #(
    parameter int N_CH = 4,
    parameter int IW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0] pending,
    input  logic [IW-1:0]   ptr,
    output logic [N_CH-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);
    always_comb begin
        logic [IW-1:0] c;
        gnt = '0;
        idx = '0;
        valid = 1'b0;
        c = '0;
        for (int k = 0; k < N_CH; k++) begin
            c = IW'((int'(ptr) + k) % N_CH);
            if (!valid && pending[c]) begin
                valid = 1'b1;
                idx = c;
                gnt[c] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin time-sharing of one binary-to-BCD converter
// ports: en (grant enable), req/bin_flat (per-channel requests and operands)
//        -> ack (one-cycle done pulse), bcd_flat (tens:ones per channel),
//           ovf (last operand > 99), busy (conversion in flight or pending)
module bcd_conv_sched
    import clock_defs_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_CH-1:0]   req,
    input  logic [N_CH*W-1:0] bin_flat,
    output logic [N_CH-1:0]   ack,
    output logic [N_CH*8-1:0] bcd_flat,
    output logic [N_CH-1:0]   ovf,
    output logic              busy
);
    localparam int IW = $clog2(N_CH);
    logic [0:0]      state, next_state;
    logic [N_CH-1:0] pending, next_pending, gnt;
    logic [IW-1:0]   rr_ptr, gnt_idx, g_idx;
    logic [W-1:0]    operand;
    logic [W-1:0]    bin_arr [N_CH];
    logic            valid, grant, sat;
    logic [BCD_W-1:0] tens, ones;
    rr_arb #(.N_CH(N_CH), .IW(IW)) u_arb (
        .pending(pending),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .idx    (g_idx),
        .valid  (valid)
    );
    bin2dec2 #(.W(W)) u_conv (
        .bin (operand),
        .tens(tens),
        .ones(ones)
    );
    always_comb begin
        for (int i = 0; i < N_CH; i++)
            bin_arr[i] = bin_flat[i*W +: W];
        grant = (state == S_IDLE) && en && valid;
        next_state = grant ? S_CONV : S_IDLE;
        // a request on the granting edge survives the clear and earns a second conversion
        next_pending = (pending & ~(grant ? gnt : '0)) | req;
        sat = operand > W'(BCD_MAX_VAL);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pending <= '0;
            rr_ptr <= '0;
            gnt_idx <= '0;
            operand <= '0;
            ack <= '0;
            bcd_flat <= '0;
            ovf <= '0;
            busy <= 1'b0;
        end else begin
            state <= next_state;
            pending <= next_pending;
            busy <= (next_state == S_CONV) | (|next_pending);
            ack <= '0;
            if (grant) begin
                operand <= bin_arr[g_idx];
                gnt_idx <= g_idx;
                rr_ptr <= IW'((int'(g_idx) + 1) % N_CH);
            end
            if (state == S_CONV) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (gnt_idx == IW'(i)) begin
                        bcd_flat[i*8 +: 8] <= sat ? {SAT_DIGIT, SAT_DIGIT} : {tens, ones};
                        ovf[i] <= sat;
                        ack[i] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched: directed self-checking bench for bcd_conv_sched
module tb_bcd_conv_sched;
    localparam int N = 4;
    localparam int W = 7;
    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   req;
    logic [N*W-1:0] bin_flat;
    logic [N-1:0]   ack;
    logic [N*8-1:0] bcd_flat;
    logic [N-1:0]   ovf;
    logic           busy;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        int         ch;
        int         val;
        logic [7:0] exp_bcd;
        logic       exp_ovf;
    } vec_t;
    vec_t vecs [8];
    bcd_conv_sched #(.N_CH(N), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .bin_flat(bin_flat),
        .ack     (ack),
        .bcd_flat(bcd_flat),
        .ovf     (ovf),
        .busy    (busy)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask
    task automatic run_single(input int ch, input int val, input logic [7:0] eb, input logic eo);
        int t;
        bin_flat[ch*W +: W] = W'(val);
        req = '0;
        req[ch] = 1'b1;
        tick;
        req = '0;
        t = 0;
        while (ack == '0 && t < 10) begin
            tick;
            t++;
        end
        chk($sformatf("latency ch%0d val%0d", ch, val), t, 2);
        chk($sformatf("ack ch%0d", ch), int'(ack), 1 << ch);
        chk($sformatf("bcd ch%0d val%0d", ch, val), int'(bcd_flat[ch*8 +: 8]), int'(eb));
        chk($sformatf("ovf ch%0d val%0d", ch, val), int'(ovf[ch]), int'(eo));
        tick;
        chk("ack drops", int'(ack), 0);
        chk("busy idle", int'(busy), 0);
    endtask
    initial begin
        int n3, got2, lat, k;
        logic last0, bad0;
        vecs[0] = '{1, 59, 8'h59, 1'b0};
        vecs[1] = '{2, 127, 8'h99, 1'b1};
        vecs[2] = '{2, 42, 8'h42, 1'b0};
        vecs[3] = '{0, 0, 8'h00, 1'b0};
        vecs[4] = '{3, 99, 8'h99, 1'b0};
        vecs[5] = '{3, 100, 8'h99, 1'b1};
        vecs[6] = '{0, 10, 8'h10, 1'b0};
        vecs[7] = '{1, 9, 8'h09, 1'b0};
        rst_n = 1'b0;
        en = 1'b1;
        req = '0;
        bin_flat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ack", int'(ack), 0);
        chk("reset bcd", int'(bcd_flat), 0);
        chk("reset ovf", int'(ovf), 0);
        chk("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < 8; i++)
            run_single(vecs[i].ch, vecs[i].val, vecs[i].exp_bcd, vecs[i].exp_ovf);
        // all four at once from rr_ptr = 0: acks ch0..ch3 every other cycle
        do_reset;
        bin_flat = {7'd99, 7'd23, 7'd7, 7'd0};
        req = 4'b1111;
        tick;
        req = '0;
        for (int t = 1; t <= 10; t++) begin
            tick;
            chk($sformatf("simul ack t%0d", t), int'(ack),
                (t == 2) ? 1 : (t == 4) ? 2 : (t == 6) ? 4 : (t == 8) ? 8 : 0);
        end
        chk("simul bcd", int'(bcd_flat), 32'h99230700);
        chk("simul rr_ptr", int'(dut.rr_ptr), 0);
        chk("simul busy", int'(busy), 0);
        // ch0 hogging request must not starve a single ch2 pulse
        do_reset;
        req = 4'b0001;
        tick;
        tick;
        req = 4'b0101;
        tick;
        req = 4'b0001;
        got2 = 0;
        lat = 99;
        last0 = 1'b0;
        bad0 = 1'b0;
        for (k = 1; k <= 12; k++) begin
            tick;
            if (ack[0] && last0 && got2 == 0)
                bad0 = 1'b1;
            if (ack[2]) begin
                if (got2 == 0)
                    lat = k;
                got2++;
            end
            if (ack != '0)
                last0 = ack[0];
        end
        chk("fair ch2 acks", got2, 1);
        chk("fair ch2 within 4", int'(lat <= 4), 1);
        chk("fair no double ch0", int'(bad0), 0);
        req = '0;
        repeat (6) tick;
        // two req[3] pulses before the grant merge into one conversion
        en = 1'b0;
        req = 4'b1000;
        tick;
        req = '0;
        tick;
        req = 4'b1000;
        tick;
        req = '0;
        en = 1'b1;
        n3 = 0;
        repeat (10) begin
            tick;
            if (ack[3])
                n3++;
        end
        chk("merge ch3 acks", n3, 1);
        // enable gates grants only
        en = 1'b0;
        req = 4'b0010;
        tick;
        req = '0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("en=0 no ack", int'(ack), 0);
            chk("en=0 busy", int'(busy), 1);
        end
        en = 1'b1;
        tick;
        chk("en rise ack wait", int'(ack), 0);
        tick;
        chk("en rise ack", int'(ack), 2);
        tick;
        // asynchronous reset in the middle of a conversion
        req = 4'b0010;
        tick;
        req = '0;
        tick;
        chk("mid conv state", int'(dut.state), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort ack", int'(ack), 0);
        chk("abort bcd", int'(bcd_flat), 0);
        chk("abort ovf", int'(ovf), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort state", int'(dut.state), 0);
        tick;
        chk("abort ack held", int'(ack), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("post abort ack", int'(ack), 0);
            chk("post abort bcd", int'(bcd_flat), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
